// File: rtl/bank_arbiter_pkg.sv
// Shared constants for the bank arbiter: requester count, index width, FSM encoding.
// No logic beyond a one-hot decode helper.
package bank_arbiter_pkg;
  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int HOLD_W       = 8;
  localparam int MAX_HOLD_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/bank_arbiter_rr_priority_pick.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping 7->0.
// Purely combinational; found is low when req is empty.
module rr_priority_pick
  import bank_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    idx  = '0;
    cand = '0;
    // Walk downward so the smallest offset from ptr is written last and wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) idx = cand;
    end
  end

  assign found = |req;
endmodule

// File: rtl/bank_arbiter.sv
// Round-robin bank arbiter with bounded hold time; 1 cycle req->grant, GAP+IDLE between owners.
// Owner holds until release, request drop or MAX_HOLD expiry (expiry alone pulses timeout).
module bank_arbiter #(
  parameter int N_REQ    = bank_arbiter_pkg::N_REQ,
  parameter int MAX_HOLD = bank_arbiter_pkg::MAX_HOLD_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_REQ-1:0]                   req,
  // 'release' is a reserved word, so the owner's release strobe takes this name.
  input  logic                               release_req,
  output logic [bank_arbiter_pkg::IDX_W-1:0] grant_cod,
  output logic                               grant_en,
  output logic [N_REQ-1:0]                   grant,
  output logic                               timeout
);
  import bank_arbiter_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  grant_cod_q, grant_cod_d;
  logic              grant_en_q, grant_en_d;
  logic              timeout_q, timeout_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              owner_req;
  logic              expired;

  rr_priority_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    grant_cod_d = grant_cod_q;
    grant_en_d  = grant_en_q;
    timeout_d   = 1'b0;
    owner_req   = req[grant_cod_q];
    expired     = (hold_q == HOLD_MAX);

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_GRANT;
          grant_cod_d = pick_idx;
          grant_en_d  = 1'b1;
          hold_d      = HOLD_W'(1);
          ptr_d       = pick_idx + IDX_W'(1);
        end
      end
      ST_GRANT: begin
        if (release_req || !owner_req || expired) begin
          state_d    = ST_GAP;
          grant_en_d = 1'b0;
          // Release wins over a coinciding expiry, so only a pure expiry flags timeout.
          timeout_d  = !release_req && owner_req;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        grant_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      grant_cod_q <= '0;
      grant_en_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      grant_cod_q <= grant_cod_d;
      grant_en_q  <= grant_en_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant_cod = grant_cod_q;
  assign grant_en  = grant_en_q;
  assign timeout   = timeout_q;
  assign grant     = grant_en_q ? onehot(grant_cod_q) : '0;
endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter: reset, single grant, round robin, timeout, wrap, coincidence, mid-grant reset.
module tb_bank_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       release_req;
  logic [2:0] grant_cod;
  logic       grant_en;
  logic [7:0] grant;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  bank_arbiter #(.N_REQ(8), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .release_req (release_req),
    .grant_cod   (grant_cod),
    .grant_en    (grant_en),
    .grant       (grant),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    req         = 8'h00;
    release_req = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    req         = 8'h00;
    release_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total++; if (grant_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", grant_en); end
    total++; if (grant_cod !== 3'd0) begin bad++; $display("FAIL reset_cod got=%0d exp=0", grant_cod); end
    total++; if (grant !== 8'h00) begin bad++; $display("FAIL reset_grant got=%b exp=00000000", grant); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    step();
    reset = 1'b1;
    step();
    total++; if (grant_en !== 1'b0) begin bad++; $display("FAIL idle_no_req_en got=%b exp=0", grant_en); end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'b0000_0100;
    step();
    total++; if (grant_en !== 1'b1 || grant_cod !== 3'd2) begin bad++; $display("FAIL single_grant en=%b cod=%0d exp en=1 cod=2", grant_en, grant_cod); end
    total++; if (grant !== 8'b0000_0100) begin bad++; $display("FAIL single_onehot got=%b exp=00000100", grant); end
    step();
    step();
    total++; if (grant_en !== 1'b1 || grant_cod !== 3'd2) begin bad++; $display("FAIL single_stable en=%b cod=%0d exp en=1 cod=2", grant_en, grant_cod); end
    release_req = 1'b1;
    step();
    total++; if (grant_en !== 1'b0 || grant !== 8'h00) begin bad++; $display("FAIL single_gap en=%b grant=%b exp en=0 grant=0", grant_en, grant); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL single_gap_timeout got=%b exp=0", timeout); end
    release_req = 1'b0;
    req = 8'h00;
    step();
    total++; if (grant_en !== 1'b0) begin bad++; $display("FAIL single_idle en=%b exp=0", grant_en); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_g;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      step();
      exp_g = 8'b1 << (k % 8);
      total++; if (grant_en !== 1'b1 || grant_cod !== 3'(k % 8)) begin bad++; $display("FAIL rr_owner k=%0d en=%b cod=%0d exp cod=%0d", k, grant_en, grant_cod, k % 8); end
      total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_onehot k=%0d got=%b exp=%b", k, grant, exp_g); end
      step();
      release_req = 1'b1;
      step();
      total++; if (grant_en !== 1'b0 || grant !== 8'h00) begin bad++; $display("FAIL rr_gap k=%0d en=%b grant=%b exp 0", k, grant_en, grant); end
      release_req = 1'b0;
      step();
      total++; if (grant_en !== 1'b0) begin bad++; $display("FAIL rr_idle k=%0d en=%b exp=0", k, grant_en); end
    end
    req = 8'h00;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'b0000_1000;
    step();
    for (int i = 0; i < 16; i++) begin
      total++; if (grant_en !== 1'b1 || grant_cod !== 3'd3 || timeout !== 1'b0) begin bad++; $display("FAIL to_hold cyc=%0d en=%b cod=%0d to=%b exp en=1 cod=3 to=0", i + 1, grant_en, grant_cod, timeout); end
      step();
    end
    total++; if (grant_en !== 1'b0 || timeout !== 1'b1) begin bad++; $display("FAIL to_pulse en=%b to=%b exp en=0 to=1", grant_en, timeout); end
    step();
    total++; if (grant_en !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL to_idle en=%b to=%b exp en=0 to=0", grant_en, timeout); end
    step();
    total++; if (grant_en !== 1'b1 || grant_cod !== 3'd3) begin bad++; $display("FAIL to_regrant en=%b cod=%0d exp en=1 cod=3", grant_en, grant_cod); end
    req = 8'h00;
  endtask

  task automatic test_drop();
    do_reset();
    req = 8'b0000_0010;
    step();
    total++; if (grant_cod !== 3'd1 || grant_en !== 1'b1) begin bad++; $display("FAIL drop_grant en=%b cod=%0d exp en=1 cod=1", grant_en, grant_cod); end
    req = 8'h00;
    step();
    total++; if (grant_en !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL drop_exit en=%b to=%b exp en=0 to=0", grant_en, timeout); end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'b0010_0000;
    step();
    total++; if (grant_cod !== 3'd5 || grant_en !== 1'b1) begin bad++; $display("FAIL wrap_first en=%b cod=%0d exp en=1 cod=5", grant_en, grant_cod); end
    req = 8'b0010_0001;
    release_req = 1'b1;
    step();
    release_req = 1'b0;
    step();
    step();
    total++; if (grant_cod !== 3'd0 || grant_en !== 1'b1) begin bad++; $display("FAIL wrap_next en=%b cod=%0d exp en=1 cod=0", grant_en, grant_cod); end
    req = 8'h00;
  endtask

  task automatic test_coincide();
    do_reset();
    req = 8'b0100_0000;
    step();
    for (int i = 0; i < 15; i++) step();
    total++; if (grant_en !== 1'b1 || grant_cod !== 3'd6) begin bad++; $display("FAIL co_hold16 en=%b cod=%0d exp en=1 cod=6", grant_en, grant_cod); end
    release_req = 1'b1;
    step();
    total++; if (grant_en !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL co_gap en=%b to=%b exp en=0 to=0", grant_en, timeout); end
    release_req = 1'b0;
    step();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL co_idle to=%b exp=0", timeout); end
    req = 8'h00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'b0001_0000;
    step();
    total++; if (grant_cod !== 3'd4 || grant_en !== 1'b1) begin bad++; $display("FAIL rm_grant en=%b cod=%0d exp en=1 cod=4", grant_en, grant_cod); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (grant_en !== 1'b0 || grant !== 8'h00) begin bad++; $display("FAIL rm_async en=%b grant=%b exp 0", grant_en, grant); end
    total++; if (timeout !== 1'b0 || grant_cod !== 3'd0) begin bad++; $display("FAIL rm_clear to=%b cod=%0d exp 0", timeout, grant_cod); end
    req = 8'hFF;
    step();
    reset = 1'b1;
    step();
    total++; if (grant_en !== 1'b1 || grant_cod !== 3'd0) begin bad++; $display("FAIL rm_restart en=%b cod=%0d exp en=1 cod=0", grant_en, grant_cod); end
    req = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_drop();
    test_wrap();
    test_coincide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
